fft_frame_feeder: RTL
=====================

Name: fft_frame_feeder

Overview:
- Captures one frame of FFT_LEN ADC samples, then streams it as complex AXI-stream words to the FFT core.
- Runs in the FFT clock domain and sits directly downstream of the FFT clock divider.
- ADC samples arrive with a 1-cycle adc_valid strobe.
- Offset-binary ADC codes are converted to signed real samples; the imaginary part is zero.

Parameters:
- FFT_LEN, 1024: samples per frame; power of two, 8..4096.
- ADC_W, 12: ADC sample width, offset-binary.
- OUT_W, 16: width of each real/imag half of tdata; OUT_W >= ADC_W.

Ports:
- clk_32m  in  1  block clock (FFT-domain clock).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request to capture and send one frame.
- adc_data  in  ADC_W  offset-binary ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- m_tdata  out  2*OUT_W  [OUT_W-1:0] = real, [2*OUT_W-1:OUT_W] = imag (always 0).
- m_tvalid  out  1  AXI-stream valid.
- m_tready  in  1  AXI-stream ready from the FFT core.
- m_tlast  out  1  marks the last sample of the frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  1-cycle pulse after the final handshake.

Behaviour:
- Clock and reset: one clock, clk_32m. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; write/read indices 0.
- Reset mid-operation: block returns to IDLE immediately. The partial frame is discarded and m_tvalid drops with the reset.
- FSM states: IDLE, CAPTURE, STREAM, DONE.
- IDLE:
  - start=1 moves to CAPTURE on the next edge.
  - adc_valid in the start cycle is not captured.
- CAPTURE:
  - Each adc_valid cycle writes the converted sample to buf[wr_idx] and increments wr_idx.
  - Gaps in adc_valid are allowed and simply wait.
  - The write with wr_idx = FFT_LEN-1 moves to STREAM; wr_idx wraps to 0.
- STREAM:
  - Samples are sent in index order 0..FFT_LEN-1.
  - m_tvalid asserts within 2 cycles of entering STREAM (allows for 1-cycle RAM read latency).
  - A beat transfers on m_tvalid & m_tready.
  - While m_tvalid & !m_tready, m_tdata and m_tlast are held stable.
  - With m_tready held high, throughput is 1 beat/cycle: no bubbles after the first beat.
  - m_tlast = 1 only on index FFT_LEN-1.
  - The handshake on the last beat deasserts m_tvalid and moves to DONE.
- DONE:
  - frame_done = 1 for exactly one cycle, then IDLE.
  - busy drops in the same cycle that IDLE is entered.
- Inputs ignored while busy: start, and adc_valid outside CAPTURE (no buffering, no error flag).
- Conversion:
  - s = adc_data with its MSB inverted (offset binary to two's complement).
  - real = s sign-extended to OUT_W.
  - Example, ADC_W=12, OUT_W=16: 12'h000 -> 16'hF800; 12'h800 -> 16'h0000; 12'hFFF -> 16'h07FF.
- Index widths are $clog2(FFT_LEN). Indices wrap naturally at FFT_LEN.
- Latency, fixed rate (adc_valid every cycle): first m_tvalid at most FFT_LEN+3 cycles after start.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_LEN, ADC_W and OUT_W defaults.
  - FSM state enum {IDLE, CAPTURE, STREAM, DONE}.
  - Function adc_to_signed(adc) implementing the conversion.
- One sub-module, fft_frame_ram:
  - Simple dual-port RAM, FFT_LEN x OUT_W, infers block RAM.
  - Synchronous write; registered read with 1-cycle latency.
  - Only the real part is stored; imag is a constant 0.
- The top level holds the FSM, the indices, and the output prefetch/hold register that decouples RAM latency from backpressure.

Test Plan:
- FFT_LEN=8, start, adc_valid every cycle with adc_data 12'h800..12'h807, m_tready=1 -> 8 consecutive beats, real 0..7, imag 0, m_tlast on beat 8 only, frame_done pulse 1 cycle later, busy=0 afterwards.
- Conversion: samples 12'h000, 12'hFFF, 12'h800, 12'h7FF -> real 16'hF800, 16'h07FF, 16'h0000, 16'hFFFF.
- Backpressure: m_tready random 50% during STREAM -> 8 beats in order, no loss or duplication; m_tdata and m_tlast stable whenever m_tvalid & !m_tready.
- adc_valid every 3rd cycle; start pulses during CAPTURE and STREAM -> exactly one frame of 8 sequential samples, extra starts ignored, adc_valid during STREAM not captured.
- Assert rst_n low after the 3rd beat of STREAM -> m_tvalid=0, busy=0, frame_done never pulses. A new start afterwards yields a clean full frame from new samples.
- Back-to-back frames: start again 1 cycle after frame_done -> second frame correct, m_tlast on its 8th beat.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults, FSM state type and the ADC code conversion used by the
// FFT frame feeder and its testbench-visible parameters.
package fft_pkg;

  localparam int FFT_LEN_DEF = 1024;
  localparam int ADC_W_DEF   = 12;
  localparam int OUT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  // Offset binary to two's complement: flip the MSB, then sign-extend from bit adc_w-1.
  function automatic logic [31:0] adc_to_signed(input logic [31:0] adc, input int adc_w);
    logic [31:0] mask;
    logic [31:0] msb;
    logic [31:0] s;
    mask = (32'd1 << adc_w) - 32'd1;
    msb  = 32'd1 << (adc_w - 1);
    s    = (adc & mask) ^ msb;
    if ((s & msb) != 32'd0) s = s | ~mask;
    return s;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read with
// read enable so the output word holds while the consumer stalls.
module fft_frame_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Captures one frame of ADC samples into a RAM, then streams it to the FFT
// core as complex AXI-stream words (imaginary part zero).
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int ADC_W   = ADC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk_32m,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               adc_valid,
  output logic [2*OUT_W-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               frame_done
);

  localparam int AW = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);

  state_t           state;
  state_t           next_state;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             tvalid_r;
  logic             tlast_r;
  logic             issued_all;
  logic             we;
  logic             re;
  logic             advance;
  logic             last_hs;
  logic [OUT_W-1:0] wdata;
  logic [OUT_W-1:0] rdata;

  assign we      = (state == CAPTURE) && adc_valid;
  assign advance = !tvalid_r || m_tready;
  assign re      = (state == STREAM) && advance && !issued_all;
  assign last_hs = tvalid_r && m_tready && tlast_r;
  assign wdata   = OUT_W'(adc_to_signed(32'(adc_data), ADC_W));

  fft_frame_ram #(
    .DEPTH(FFT_LEN),
    .WIDTH(OUT_W),
    .AW   (AW)
  ) u_ram (
    .clk  (clk_32m),
    .we   (we),
    .waddr(wr_idx),
    .wdata(wdata),
    .re   (re),
    .raddr(rd_idx),
    .rdata(rdata)
  );

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CAPTURE;
      CAPTURE: if (we && (wr_idx == LAST_IDX)) next_state = STREAM;
      STREAM:  if (last_hs) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  // The RAM output register is the hold stage: a new read is issued only when
  // the current beat is absent or being accepted, so stalls freeze it in place.
  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      issued_all <= 1'b0;
    end else begin
      if (state == IDLE)  wr_idx <= '0;
      else if (we)        wr_idx <= wr_idx + AW'(1);

      if (state != STREAM) begin
        rd_idx     <= '0;
        tvalid_r   <= 1'b0;
        tlast_r    <= 1'b0;
        issued_all <= 1'b0;
      end else if (advance) begin
        if (re) begin
          rd_idx   <= rd_idx + AW'(1);
          tvalid_r <= 1'b1;
          tlast_r  <= (rd_idx == LAST_IDX);
          if (rd_idx == LAST_IDX) issued_all <= 1'b1;
        end else begin
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      end
    end
  end

  // RAM output has no reset, so the data lanes are gated to read zero when idle.
  assign m_tvalid = tvalid_r;
  assign m_tlast  = tlast_r;
  assign m_tdata  = {{OUT_W{1'b0}}, (tvalid_r ? rdata : {OUT_W{1'b0}})};

endmodule
